// File: rtl/div_unit.sv
// Iterative 32-bit integer divider (div.w/mod.w/div.wu/mod.wu): one restoring step per
// cycle with fixed 34-cycle latency. Operands are converted to magnitudes and the signs are fixed up at the end.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [DATA_W-1:0]  dvd_q, dvd_d;      // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0]  dvs_q, dvs_d;
  logic [DATA_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               done_q, done_d;

  logic signed [DATA_W-1:0] a_s, b_s;
  logic               signed_op, accept;
  logic [DATA_W:0]    shifted, diff;
  logic               carry, no_borrow;
  logic [DATA_W-1:0]  quo_val, rem_val, res_val;

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] x, input logic en);
    return en ? (~x + DATA_W'(1)) : x;
  endfunction

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x);
    return neg_if(DATA_W'(x), x[DATA_W-1]);
  endfunction

  assign a_s       = a;
  assign b_s       = b;
  assign signed_op = ~op[1];
  assign accept    = (state_q == IDLE) && start && !flush;

  // Trial subtract; diff[DATA_W] is the sign of the difference and always agrees
  // with the carry because the partial remainder stays below twice the divisor.
  assign shifted            = {rem_q, dvd_q[DATA_W-1]};
  assign {carry, diff}      = {1'b0, shifted} + {1'b0, ~{1'b0, dvs_q}} + {{(DATA_W+1){1'b0}}, 1'b1};
  assign no_borrow          = carry & ~diff[DATA_W];

  // Divide by zero naturally yields an all-ones magnitude; force it past the sign fix-up.
  assign quo_val = (dvs_q == '0) ? '1 : neg_if(dvd_q, ~op_q[1] & (sign_a_q ^ sign_b_q));
  assign rem_val = neg_if(rem_q, ~op_q[1] & sign_a_q);
  assign res_val = op_q[0] ? rem_val : quo_val;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d     = op;
          sign_a_d = signed_op & a[DATA_W-1];
          sign_b_d = signed_op & b[DATA_W-1];
          dvd_d    = signed_op ? magnitude(a_s) : a;
          dvs_d    = signed_op ? magnitude(b_s) : b;
          rem_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        rem_d = no_borrow ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        dvd_d = {dvd_q[DATA_W-2:0], no_borrow};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = FINISH;
      end
      FINISH: begin
        result_d = res_val;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed bench for div_unit: expected results are queued at issue
// time and a monitor compares them against each done pulse.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rstn, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  always #5 clk = ~clk;

  div_unit dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    bit is_mod, is_signed;
    is_mod    = o[0];
    is_signed = !o[1];
    if (y == 32'h0) return is_mod ? x : 32'hFFFFFFFF;
    if (is_signed) begin
      if (x == 32'h80000000 && y == 32'hFFFFFFFF) return is_mod ? 32'h0 : 32'h80000000;
      sx = x;
      sy = y;
      return is_mod ? 32'(sx % sy) : 32'(sx / sy);
    end
    return is_mod ? (x % y) : (x / y);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 with result %h, expected no done at %0t", result, $time);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Called #1 after a rising edge with the unit idle or in its done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit poke);
    int cnt;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    exp_q.push_back(model(o, x, y));
    last_res = model(o, x, y);
    @(posedge clk); #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    cnt   = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      start = (poke && cnt >= 5 && cnt <= 8);
      op    = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("busy_cycles", 32'(cnt), 32'd33);
    check("done_pulse", {31'b0, done}, 32'd1);
  endtask

  task automatic issue_untracked(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          cat;
    rstn = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    last_res = '0;
    #12;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'h0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // Directed cases, issued back to back
    run_op(2'b00, 32'h00000064, 32'h00000007, 1'b0);
    run_op(2'b01, 32'h00000064, 32'h00000007, 1'b0);
    run_op(2'b00, 32'hFFFFFFF9, 32'h00000002, 1'b0);
    run_op(2'b01, 32'hFFFFFFF9, 32'h00000002, 1'b0);
    run_op(2'b10, 32'hFFFFFFFF, 32'h00000002, 1'b0);
    run_op(2'b00, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op(2'b01, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op(2'b10, 32'h00000005, 32'h00000000, 1'b0);
    run_op(2'b11, 32'h00000005, 32'h00000000, 1'b0);
    run_op(2'b00, 32'hFFFFFFFB, 32'h00000000, 1'b1);
    @(posedge clk); #1;
    check("busy_start_not_queued", {31'b0, busy}, 32'd0);

    // Flush at CALC iteration 10, then restart in the following cycle
    issue_untracked(2'b00, 32'd1000, 32'd3);
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_result_held", result, last_res);
    run_op(2'b01, 32'd1000, 32'd7, 1'b0);

    // Flush in FINISH suppresses done and the result update
    @(posedge clk); #1;
    issue_untracked(2'b00, 32'd999, 32'd9);
    repeat (32) begin @(posedge clk); #1; end
    check("finish_busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("finish_flush_done", {31'b0, done}, 32'd0);
    check("finish_flush_busy", {31'b0, busy}, 32'd0);
    check("finish_flush_result", result, last_res);

    // Asynchronous reset mid-CALC
    run_op(2'b00, 32'd1000, 32'd3, 1'b0);
    @(posedge clk); #1;
    issue_untracked(2'b00, 32'h12345678, 32'd11);
    repeat (15) begin @(posedge clk); #1; end
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_done", {31'b0, done}, 32'd0);
    check("async_rst_result", result, 32'h0);
    last_res = '0;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    run_op(2'b00, 32'h00000064, 32'h00000007, 1'b0);

    // start together with flush in IDLE is ignored
    @(posedge clk); #1;
    op = 2'b00; a = 32'd50; b = 32'd5;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("start_flush_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    check("start_flush_idle", {31'b0, busy}, 32'd0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      cat = $urandom_range(0, 5);
      ra  = $urandom;
      rb  = $urandom;
      case (cat)
        0: rb = 32'h0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: begin
          ra = $urandom_range(0, 1000);
          rb = $urandom_range(1, 20);
          if ($urandom_range(0, 1) == 1) ra = -ra;
          if ($urandom_range(0, 1) == 1) rb = -rb;
        end
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      run_op(2'($urandom_range(0, 3)), ra, rb, ($urandom_range(0, 4) == 0));
    end

    repeat (3) begin @(posedge clk); #1; end
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk drives all state, and rstn low resets all state immediately without waiting for a clock edge.
REQ-002 clk  input  1  rising-edge clock for all sequential state.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a divide; sampled only in IDLE.
REQ-005 op  input  2  operation select: 00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu.
REQ-006 a  input  32  dividend, sampled on the accepting edge.
REQ-007 b  input  32  divisor, sampled on the accepting edge.
REQ-008 flush  input  1  synchronous abort from a pipeline redirect.
REQ-009 busy  output  1  high while an operation is in flight.
REQ-010 done  output  1  one-cycle pulse marking a valid result.
REQ-011 result  output  32  quotient or remainder; held until the next done.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and FINISH; busy SHALL equal (state != IDLE).
REQ-013 On the accepting edge (IDLE, start=1, flush=0), the block SHALL latch op, the sign of a, the sign of b, |a| and |b|, clear the 5-bit iteration counter and go to CALC.
- Signed ops: |x| is the two's-complement magnitude; |0x80000000| = 0x80000000 as unsigned.
- Unsigned ops: operands are used as-is and both signs are taken as 0.
REQ-014 CALC SHALL perform one restoring step per cycle:
- Shift partial remainder left 1, bringing in the next dividend MSB.
- Trial-subtract: 33-bit partial + ~{0,divisor} + 1.
- Carry-out 1 (no borrow): keep the difference and set quotient bit = 1.
- Carry-out 0: restore the partial remainder and set quotient bit = 0.
REQ-015 After 32 CALC cycles (counter 31 at the edge), the FSM SHALL go to FINISH; FINISH SHALL last exactly one cycle.
REQ-016 On the edge leaving FINISH, the block SHALL register result and set done=1 for one cycle, and the FSM SHALL return to IDLE.
- Quotient is negated if sign_a XOR sign_b (signed ops).
- Remainder is negated if sign_a (signed ops).
- div ops output the quotient; mod ops output the remainder.
REQ-017 Latency SHALL be fixed: with start accepted at edge E0, busy SHALL be high for the 33 cycles after E0..E32, and done SHALL be high in the cycle after E33.
REQ-018 start asserted in the done cycle SHALL be accepted, giving back-to-back operations every 34 cycles.
REQ-019 start asserted while busy=1 SHALL be ignored; it SHALL not be queued.
REQ-020 Divide by zero (b=0), for all ops, SHALL give quotient 0xFFFFFFFF and remainder a (unmodified), after the full 34-cycle latency with no exception output.
REQ-021 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0x00000000.
REQ-022 flush=1 in any state SHALL, at the next edge, force IDLE.
- done stays 0 and result is unchanged.
- Counter and partial state become don't-care.
REQ-023 flush and start asserted in the same IDLE cycle: flush SHALL win and start SHALL be ignored.
REQ-024 flush in the FINISH cycle SHALL suppress done and the result update.
REQ-025 done SHALL be 0 in every cycle except the single cycle following FINISH.

Reset
REQ-026 While rstn=0, the block SHALL hold state=IDLE, busy=0, done=0, result=0x00000000, counter=0 and all operand/partial registers = 0.
REQ-027 rstn asserted mid-operation SHALL abort the operation with no done pulse; the first start after rstn deasserts SHALL be accepted normally.

Verification
REQ-028 The bench SHALL cover div.w a=0x00000064, b=0x00000007: busy high for exactly 33 cycles, then done=1 with result=0x0000000E, and mod.w on the same operands gives 0x00000002.
REQ-029 The bench SHALL cover div.w a=0xFFFFFFF9 (-7), b=0x00000002: result=0xFFFFFFFD, and mod.w on the same operands gives 0xFFFFFFFF.
REQ-030 The bench SHALL cover div.wu a=0xFFFFFFFF, b=0x00000002 giving 0x7FFFFFFF, div.w 0x80000000/0xFFFFFFFF giving 0x80000000, and mod.w on that pair giving 0x00000000.
REQ-031 The bench SHALL cover b=0 with a=0x00000005: div.wu gives 0xFFFFFFFF, mod.wu gives 0x00000005, and div.w with a=0xFFFFFFFB gives 0xFFFFFFFF.
REQ-032 The bench SHALL cover flush at CALC iteration 10: busy=0 the next cycle, no done, result keeps its prior value, and a start in the following cycle completes correctly.
REQ-033 The bench SHALL cover rstn pulsed low mid-CALC: busy, done and result go to 0 before the next clock edge, and start asserted during the busy window plus start asserted together with flush are both ignored.
